// File: rtl/wdt_pkg.sv
// Shared watchdog definitions: FSM state encoding, default widths and the
// register map the AXI wrapper decodes.
package wdt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_TIMEOUT = 2'd2
    } wdt_state_e;

    localparam int WDT_CNT_W = 32;

    localparam logic [11:0] WDT_OFF_WDEN   = 12'h100;
    localparam logic [11:0] WDT_OFF_WDLIVE = 12'h200;
    localparam logic [11:0] WDT_OFF_WTOCNT = 12'h300;

    // Word (32-bit) addresses of the same registers.
    localparam logic [9:0] WDT_WA_WDEN   = 10'h040;
    localparam logic [9:0] WDT_WA_WDLIVE = 10'h080;
    localparam logic [9:0] WDT_WA_WTOCNT = 10'h0C0;

endpackage

// File: rtl/wdt_prescaler.sv
// Watchdog tick generator: one tick every PRESCALE enabled cycles, restarted
// by i_clr and held at zero while disabled.
module wdt_prescaler #(
    parameter int PRESCALE = 1,
    parameter int PRE_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam logic [PRE_W-1:0] LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] r_pre;
    logic             w_last;

    assign w_last = (r_pre == LAST);
    assign o_tick = i_en & w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
        end else if (i_clr || !i_en || w_last) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

endmodule

// File: rtl/wdt_timer.sv
// Watchdog countdown core: arms on a WDEN rising edge, restarts on a WDLIVE
// rising edge, and raises a sticky WTO once WTOCNT+1 ticks pass unkicked.
module wdt_timer
    import wdt_pkg::*;
#(
    parameter int CNT_W    = WDT_CNT_W,
    parameter int PRESCALE = 1,
    parameter int PRE_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wden_i,
    input  logic             wdlive_i,
    input  logic [CNT_W-1:0] wtocnt_i,
    output logic             wto_o,
    output logic             active_o,
    output logic [CNT_W-1:0] count_o
);

    wdt_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic [CNT_W-1:0] r_shadow, w_shadow_nxt;
    logic             r_wto, w_wto_nxt;
    logic             r_wden_q, r_wdlive_q;
    logic             w_arm, w_kick, w_tick, w_counting;

    assign w_arm      = wden_i & ~r_wden_q;
    assign w_kick     = wdlive_i & ~r_wdlive_q;
    assign w_counting = (r_state == ST_COUNT);

    // Prescaler restarts on kick and when the watchdog is being disabled.
    wdt_prescaler #(
        .PRESCALE (PRESCALE),
        .PRE_W    (PRE_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_counting),
        .i_clr  (w_kick | ~wden_i),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_shadow_nxt = r_shadow;
        w_wto_nxt    = r_wto;
        case (r_state)
            ST_IDLE: begin
                if (w_arm) begin
                    w_state_nxt  = ST_COUNT;
                    w_shadow_nxt = wtocnt_i;
                    w_count_nxt  = '0;
                end
            end
            ST_COUNT: begin
                if (!wden_i) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                    w_wto_nxt   = 1'b0;
                end else if (w_kick) begin
                    w_shadow_nxt = wtocnt_i;
                    w_count_nxt  = '0;
                end else if (w_tick && (r_count == r_shadow)) begin
                    w_state_nxt = ST_TIMEOUT;
                    w_wto_nxt   = 1'b1;
                end else if (w_tick) begin
                    w_count_nxt = r_count + CNT_W'(1);
                end
            end
            ST_TIMEOUT: begin
                if (!wden_i) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                    w_wto_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
                w_wto_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_shadow   <= '0;
            r_wto      <= 1'b0;
            r_wden_q   <= 1'b0;
            r_wdlive_q <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_shadow   <= w_shadow_nxt;
            r_wto      <= w_wto_nxt;
            r_wden_q   <= wden_i;
            r_wdlive_q <= wdlive_i;
        end
    end

    assign wto_o    = r_wto;
    assign active_o = w_counting;
    assign count_o  = r_count;

endmodule

// File: tb/tb_wdt_timer.sv
// Bench for wdt_timer: two instances (PRESCALE=1/32-bit and PRESCALE=4/4-bit)
// share stimulus; an elapsed-time reference model feeds a per-instance scoreboard.
module tb_wdt_timer;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_TO   = 2;

    typedef struct packed {
        logic        wto;
        logic        act;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wden = 1'b0;
    logic        wdlive = 1'b0;
    logic [31:0] wtocnt = 32'd0;

    logic        wto0, act0, wto1, act1;
    logic [31:0] cnt0;
    logic [3:0]  cnt1;

    always #5 clk = ~clk;

    wdt_timer #(.CNT_W(32), .PRESCALE(1), .PRE_W(8)) u_p1 (
        .clk(clk), .rst(rst), .wden_i(wden), .wdlive_i(wdlive), .wtocnt_i(wtocnt),
        .wto_o(wto0), .active_o(act0), .count_o(cnt0)
    );

    wdt_timer #(.CNT_W(4), .PRESCALE(4), .PRE_W(2)) u_p4 (
        .clk(clk), .rst(rst), .wden_i(wden), .wdlive_i(wdlive), .wtocnt_i(wtocnt[3:0]),
        .wto_o(wto1), .active_o(act1), .count_o(cnt1)
    );

    exp_t   q0[$];
    exp_t   q1[$];
    int     mode[2];
    longint lim[2];
    longint el[2];
    logic   pw, pl;
    int     n_pass = 0;
    int     n_chk  = 0;
    int     cyc    = 0;

    function automatic int ps(int k);
        return (k == 0) ? 1 : 4;
    endfunction

    // Expected outputs from elapsed time since arm/kick: count = elapsed/PRESCALE.
    function automatic exp_t mexp(int k);
        exp_t e;
        e.wto = (mode[k] == M_TO);
        e.act = (mode[k] == M_RUN);
        if (mode[k] == M_RUN)     e.cnt = 32'(el[k] / ps(k));
        else if (mode[k] == M_TO) e.cnt = 32'(lim[k]);
        else                      e.cnt = 32'd0;
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mode[k] = M_IDLE;
            lim[k]  = 0;
            el[k]   = 0;
        end
        pw = 1'b0;
        pl = 1'b0;
    endtask

    task automatic step();
        longint nin;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                nin = (k == 0) ? longint'(wtocnt) : longint'(wtocnt[3:0]);
                case (mode[k])
                    M_IDLE: if (wden && !pw) begin
                        mode[k] = M_RUN;
                        lim[k]  = nin;
                        el[k]   = 0;
                    end
                    M_RUN: begin
                        if (!wden) mode[k] = M_IDLE;
                        else if (wdlive && !pl) begin
                            lim[k] = nin;
                            el[k]  = 0;
                        end else begin
                            el[k]++;
                            if (el[k] == (lim[k] + 1) * ps(k)) mode[k] = M_TO;
                        end
                    end
                    default: if (!wden) mode[k] = M_IDLE;
                endcase
            end
            pw = wden;
            pl = wdlive;
        end
        q0.push_back(mexp(0));
        q1.push_back(mexp(1));
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic chk(string nm, exp_t got, exp_t e);
        n_chk++;
        if (got === e) n_pass++;
        else $display("FAIL %s cyc=%0d got wto=%b act=%b cnt=%0d exp wto=%b act=%b cnt=%0d",
                      nm, cyc, got.wto, got.act, got.cnt, e.wto, e.act, e.cnt);
    endtask

    // Monitor: outputs are presented every cycle; compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("p1", {wto0, act0, cnt0}, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("p4", {wto1, act1, 28'd0, cnt1}, e);
            end
        end
    end

    initial begin
        model_reset();
        // Held in reset, then idle with enable low.
        wtocnt = 32'd5;
        run(3);
        rst = 1'b0;
        run(20);

        // Plain timeout, enable held.
        wden = 1'b1;
        run(32);
        wden = 1'b0;
        run(2);

        // Kick coincident with the terminal tick of the PRESCALE=1 instance.
        wden = 1'b1;
        run(6);
        wdlive = 1'b1;
        run(1);
        wdlive = 1'b0;
        run(30);
        wden = 1'b0;
        run(2);

        // Shadow unaffected by live WTOCNT changes until a kick.
        wtocnt = 32'd10;
        wden = 1'b1;
        run(4);
        wtocnt = 32'd2;
        run(15);
        wden = 1'b0;
        run(2);
        wtocnt = 32'd10;
        wden = 1'b1;
        run(3);
        wtocnt = 32'd2;
        wdlive = 1'b1;
        run(1);
        wdlive = 1'b0;
        run(14);

        // Zero count, disable from TIMEOUT, re-arm.
        wden = 1'b0;
        wtocnt = 32'd0;
        run(2);
        wden = 1'b1;
        run(6);
        wden = 1'b0;
        run(1);
        wden = 1'b1;
        run(6);
        wden = 1'b0;
        run(2);

        // Async reset mid-count: outputs must clear between edges.
        wtocnt = 32'd10;
        wden = 1'b1;
        run(4);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_p1", {wto0, act0, cnt0}, '0);
        chk("rst_async_p4", {wto1, act1, 28'd0, cnt1}, '0);
        model_reset();
        q0.delete();
        q1.delete();
        q0.push_back(mexp(0));
        q1.push_back(mexp(1));
        wden = 1'b0;
        run(2);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wdlive = 1'b1;
            run(2);
            wdlive = 1'b0;
            run(2);
        end
        wden = 1'b1;
        run(8);
        wden = 1'b0;
        run(2);

        // All-ones count: 4-bit instance counts to 15 without wrapping.
        wtocnt = 32'hFFFF_FFFF;
        wden = 1'b1;
        run(70);
        wden = 1'b0;
        run(2);

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 24) == 0) wden = ~wden;
            if ($urandom_range(0, 5) == 0) wdlive = ~wdlive;
            if ($urandom_range(0, 7) == 0)
                wtocnt = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 7));
            run(1);
        end

        wden = 1'b0;
        run(2);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
